// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg : RV32I opcodes, immediate formats and decode-pipe record
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam int RV_XLEN = 32;
  localparam int RV_PC_W = 6;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic                 valid;
    logic [RV_PC_W-1:0]   pc;
    logic [6:0]           opcode;
    logic [4:0]           rd;
    logic [4:0]           rs1;
    logic [4:0]           rs2;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [RV_XLEN-1:0]   imm;
    logic [RV_XLEN-1:0]   rs1_data;
    logic [RV_XLEN-1:0]   rs2_data;
    logic                 illegal;
  } decode_pipe_t;

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP: is_legal = 1'b1;
      default:                                  is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP: uses_rs1 = 1'b1;
      default:                       uses_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] opc);
    case (opc)
      OPC_BRANCH, OPC_STORE, OPC_OP: uses_rs2 = 1'b1;
      default:                       uses_rs2 = 1'b0;
    endcase
  endfunction

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm_fmt = IMM_I;
      OPC_STORE:                      imm_fmt = IMM_S;
      OPC_BRANCH:                     imm_fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
      OPC_JAL:                        imm_fmt = IMM_J;
      default:                        imm_fmt = IMM_NONE;
    endcase
  endfunction

  function automatic logic [RV_XLEN-1:0] gen_imm(input logic [31:0] inst,
                                                 input imm_fmt_e    fmt);
    case (fmt)
      IMM_I:   gen_imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   gen_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   gen_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                          inst[11:8], 1'b0};
      IMM_U:   gen_imm = {inst[31:12], 12'b0};
      IMM_J:   gen_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                          inst[30:21], 1'b0};
      default: gen_imm = '0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_regfile.sv
// ----------------------------------------------------------------------------
// decode_regfile : NREGS x XLEN register file, 2 async reads / 1 write, x0 = 0
// Optional macro DECODE_WB_BYPASS_EN: same-cycle write-through on reads.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_regfile #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_idx_i,
  input  logic [4:0]      rs2_idx_i,
  output logic [XLEN-1:0] rs1_data_o,
  output logic [XLEN-1:0] rs2_data_o,
  input  logic            wb_en_i,
  input  logic [4:0]      wb_rd_i,
  input  logic [XLEN-1:0] wb_data_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  assign wr_en = wb_en_i && (wb_rd_i != 5'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [4:0] idx);
    if (idx == 5'd0) begin
      read_port = '0;
`ifdef DECODE_WB_BYPASS_EN
    end else if (wr_en && (wb_rd_i == idx)) begin
      read_port = wb_data_i;
`endif
    end else begin
      read_port = regs_q[idx];
    end
  endfunction

  assign rs1_data_o = read_port(rs1_idx_i);
  assign rs2_data_o = read_port(rs2_idx_i);

endmodule

`default_nettype wire

// File: rtl/decode_block.sv
// ----------------------------------------------------------------------------
// decode_block : RV32I decode stage with regfile read and load-use bubble.
// Optional macro DECODE_WB_BYPASS_EN (applied inside decode_regfile). Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module decode_block
  import riscv_pkg::*;
#(
  parameter int XLEN  = RV_XLEN,
  parameter int PC_W  = RV_PC_W,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     fetch_pipe,
  input  logic [PC_W-1:0] fetch_pc,
  input  logic            fetch_valid,
  input  logic            stall_in,
  input  logic            flush_in,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            stall_out,
  output logic            dec_valid,
  output logic [PC_W-1:0] dec_pc,
  output logic [6:0]      dec_opcode,
  output logic [4:0]      dec_rd,
  output logic [4:0]      dec_rs1,
  output logic [4:0]      dec_rs2,
  output logic [2:0]      dec_funct3,
  output logic [6:0]      dec_funct7,
  output logic [XLEN-1:0] dec_imm,
  output logic [XLEN-1:0] dec_rs1_data,
  output logic [XLEN-1:0] dec_rs2_data,
  output logic            dec_illegal
);

  decode_pipe_t    dec_q;
  decode_pipe_t    dec_d;
  decode_pipe_t    cap;
  logic [6:0]      opc;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic            hazard;

  assign opc = fetch_pipe[6:0];

  decode_regfile #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .rs1_idx_i  (fetch_pipe[19:15]),
    .rs2_idx_i  (fetch_pipe[24:20]),
    .rs1_data_o (rf_rs1_data),
    .rs2_data_o (rf_rs2_data),
    .wb_en_i    (wb_en),
    .wb_rd_i    (wb_rd),
    .wb_data_i  (wb_data)
  );

  // A load sitting in the decode pipe cannot forward its data to the very
  // next instruction; hold that instruction in fetch for one bubble.
  assign hazard = dec_q.valid && (dec_q.opcode == OPC_LOAD) &&
                  (dec_q.rd != 5'd0) && fetch_valid &&
                  ((uses_rs1(opc) && (dec_q.rd == fetch_pipe[19:15])) ||
                   (uses_rs2(opc) && (dec_q.rd == fetch_pipe[24:20])));

  assign stall_out = stall_in || hazard;

  always_comb begin
    cap = '0;
    if (fetch_valid) begin
      cap.valid    = 1'b1;
      cap.pc       = fetch_pc;
      cap.opcode   = opc;
      cap.rd       = fetch_pipe[11:7];
      cap.rs1      = fetch_pipe[19:15];
      cap.rs2      = fetch_pipe[24:20];
      cap.funct3   = fetch_pipe[14:12];
      cap.funct7   = fetch_pipe[31:25];
      cap.imm      = gen_imm(fetch_pipe, imm_fmt(opc));
      cap.rs1_data = rf_rs1_data;
      cap.rs2_data = rf_rs2_data;
      cap.illegal  = !is_legal(opc);
    end
  end

  always_comb begin
    dec_d = dec_q;
    if (flush_in) begin
      dec_d = '0;
    end else if (stall_in) begin
      dec_d = dec_q;
    end else if (hazard) begin
      dec_d = '0;
    end else begin
      dec_d = cap;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q <= '0;
    end else begin
      dec_q <= dec_d;
    end
  end

  assign dec_valid    = dec_q.valid;
  assign dec_pc       = dec_q.pc;
  assign dec_opcode   = dec_q.opcode;
  assign dec_rd       = dec_q.rd;
  assign dec_rs1      = dec_q.rs1;
  assign dec_rs2      = dec_q.rs2;
  assign dec_funct3   = dec_q.funct3;
  assign dec_funct7   = dec_q.funct7;
  assign dec_imm      = dec_q.imm;
  assign dec_rs1_data = dec_q.rs1_data;
  assign dec_rs2_data = dec_q.rs2_data;
  assign dec_illegal  = dec_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_decode_block.sv
// ----------------------------------------------------------------------------
// tb_decode_block : directed stimulus against a behavioural decode-stage model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_decode_block;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] fetch_pipe;
  logic [5:0]  fetch_pc;
  logic        fetch_valid, stall_in, flush_in, wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall_out, dec_valid, dec_illegal;
  logic [5:0]  dec_pc;
  logic [6:0]  dec_opcode, dec_funct7;
  logic [4:0]  dec_rd, dec_rs1, dec_rs2;
  logic [2:0]  dec_funct3;
  logic [31:0] dec_imm, dec_rs1_data, dec_rs2_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_block dut (
    .clk(clk), .rst_n(rst_n), .fetch_pipe(fetch_pipe), .fetch_pc(fetch_pc),
    .fetch_valid(fetch_valid), .stall_in(stall_in), .flush_in(flush_in),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .stall_out(stall_out),
    .dec_valid(dec_valid), .dec_pc(dec_pc), .dec_opcode(dec_opcode),
    .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_funct3(dec_funct3), .dec_funct7(dec_funct7), .dec_imm(dec_imm),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dec_illegal(dec_illegal)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        valid;
    logic [5:0]  pc;
    logic [6:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm, d1, d2;
    logic        ill;
  } m_t;

  m_t          m_dec;
  logic        m_known;
  logic [31:0] m_regs [32];

  function automatic logic m_legal(input logic [6:0] op);
    case (op)
      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
      7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Sign extension by left-justifying the field and arithmetic-shifting back.
  function automatic logic [31:0] m_imm(input logic [31:0] in);
    case (in[6:0])
      7'b1100111, 7'b0000011, 7'b0010011:
        return 32'($signed({in[31:20], 20'b0}) >>> 20);
      7'b0100011:
        return 32'($signed({in[31:25], in[11:7], 20'b0}) >>> 20);
      7'b1100011:
        return 32'($signed({in[31], in[7], in[30:25], in[11:8], 1'b0, 19'b0}) >>> 19);
      7'b0110111, 7'b0010111:
        return {in[31:12], 12'b0};
      7'b1101111:
        return 32'($signed({in[31], in[19:12], in[20], in[30:21], 1'b0, 11'b0}) >>> 11);
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] i);
    if (i == 5'd0) return 32'd0;
`ifdef DECODE_WB_BYPASS_EN
    if (wb_en && wb_rd == i) return wb_data;
`endif
    return m_regs[i];
  endfunction

  function automatic logic m_hazard();
    logic [6:0] op;
    logic       u1, u2;
    op = fetch_pipe[6:0];
    u1 = (op == 7'b1100111) || (op == 7'b1100011) || (op == 7'b0000011) ||
         (op == 7'b0100011) || (op == 7'b0010011) || (op == 7'b0110011);
    u2 = (op == 7'b1100011) || (op == 7'b0100011) || (op == 7'b0110011);
    return m_dec.valid && m_dec.op == 7'b0000011 && m_dec.rd != 0 && fetch_valid &&
           ((u1 && m_dec.rd == fetch_pipe[19:15]) || (u2 && m_dec.rd == fetch_pipe[24:20]));
  endfunction

  function automatic m_t m_capture();
    m_t c;
    c = '0;
    if (fetch_valid) begin
      c.valid = 1'b1;
      c.pc    = fetch_pc;
      c.op    = fetch_pipe[6:0];
      c.rd    = fetch_pipe[11:7];
      c.rs1   = fetch_pipe[19:15];
      c.rs2   = fetch_pipe[24:20];
      c.f3    = fetch_pipe[14:12];
      c.f7    = fetch_pipe[31:25];
      c.ill   = !m_legal(fetch_pipe[6:0]);
      c.imm   = c.ill ? 32'd0 : m_imm(fetch_pipe);
      c.d1    = m_read(fetch_pipe[19:15]);
      c.d2    = m_read(fetch_pipe[24:20]);
    end
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_dec   <= '0;
      m_known <= 1'b1;
      for (int i = 0; i < 32; i++) m_regs[i] <= 32'd0;
    end else begin
      if (flush_in) begin
        m_dec <= '0; m_known <= 1'b1;
      end else if (stall_in) begin
        m_dec <= m_dec;
      end else if (m_hazard()) begin
        m_dec <= '0; m_known <= 1'b1;
      end else begin
        m_dec <= m_capture(); m_known <= fetch_valid;
      end
      if (wb_en && wb_rd != 0) m_regs[wb_rd] <= wb_data;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("valid", 32'(dec_valid), 32'(m_dec.valid));
    chk("illegal", 32'(dec_illegal), 32'(m_dec.ill));
    chk("stall_out", 32'(stall_out), 32'(stall_in | m_hazard()));
    if (m_known) begin
      chk("pc", 32'(dec_pc), 32'(m_dec.pc));
      chk("opcode", 32'(dec_opcode), 32'(m_dec.op));
      chk("rd", 32'(dec_rd), 32'(m_dec.rd));
      chk("rs1", 32'(dec_rs1), 32'(m_dec.rs1));
      chk("rs2", 32'(dec_rs2), 32'(m_dec.rs2));
      chk("funct3", 32'(dec_funct3), 32'(m_dec.f3));
      chk("funct7", 32'(dec_funct7), 32'(m_dec.f7));
      chk("imm", dec_imm, m_dec.imm);
      chk("rs1_data", dec_rs1_data, m_dec.d1);
      chk("rs2_data", dec_rs2_data, m_dec.d2);
    end
  end

  // ---------------- directed stimulus ----------------
  localparam logic [31:0] I_ADDI  = 32'hFFB00093;
  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
  localparam logic [31:0] I_LUI   = 32'h123450B7;
  localparam logic [31:0] I_LW    = 32'h00012283;  // lw  x5,0(x2)
  localparam logic [31:0] I_ADD   = 32'h00128333;  // add x6,x5,x1
  localparam logic [31:0] I_ADD0  = 32'h00100333;  // add x6,x0,x1
  localparam logic [31:0] I_ADD87 = 32'h00038433;  // add x8,x7,x0
  localparam logic [31:0] I_ADD80 = 32'h00000433;  // add x8,x0,x0
  localparam logic [31:0] I_ADD81 = 32'h00008433;  // add x8,x1,x0

  task automatic drive(input logic [31:0] inst, input logic [5:0] pc,
                       input logic fv, input logic st, input logic fl);
    fetch_pipe = inst; fetch_pc = pc; fetch_valid = fv; stall_in = st; flush_in = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input logic [4:0] rd, input logic [31:0] d);
    wb_en = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(32'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    wb_en = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(dec_valid), 32'd0);
    chk("rst_imm", dec_imm, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    wb(5'd2, 32'h100); wb(5'd1, 32'h11); wb(5'd5, 32'h55);

    drive(I_ADDI, 6'd3, 1'b1, 1'b0, 1'b0); tick();
    chk("addi_valid", 32'(dec_valid), 32'd1);
    chk("addi_pc", 32'(dec_pc), 32'd3);
    chk("addi_rd", 32'(dec_rd), 32'd1);
    chk("addi_imm", dec_imm, 32'hFFFFFFFB);
    chk("addi_ill", 32'(dec_illegal), 32'd0);
    chk("model_addi_imm", m_dec.imm, 32'hFFFFFFFB);

    drive(I_BEQ, 6'd4, 1'b1, 1'b0, 1'b0); tick();
    chk("beq_imm", dec_imm, 32'hFFFFFFFC);
    chk("model_beq_imm", m_dec.imm, 32'hFFFFFFFC);

    drive(I_LUI, 6'd5, 1'b1, 1'b0, 1'b0); tick();
    chk("lui_imm", dec_imm, 32'h12345000);
    chk("model_lui_imm", m_dec.imm, 32'h12345000);

    // load-use on rs1
    drive(I_LW, 6'd6, 1'b1, 1'b0, 1'b0); tick();
    drive(I_ADD, 6'd7, 1'b1, 1'b0, 1'b0); #1;
    chk("lu_stall", 32'(stall_out), 32'd1);
    tick();
    chk("lu_bubble", 32'(dec_valid), 32'd0);
    chk("lu_stall_clear", 32'(stall_out), 32'd0);
    tick();
    chk("lu_add_valid", 32'(dec_valid), 32'd1);
    chk("lu_add_rs1", 32'(dec_rs1), 32'd5);
    chk("lu_add_rs1_data", dec_rs1_data, 32'h55);
    chk("lu_add_rs2_data", dec_rs2_data, 32'h11);

    // same sequence with rs1 = x0: no stall
    drive(I_LW, 6'd8, 1'b1, 1'b0, 1'b0); tick();
    drive(I_ADD0, 6'd9, 1'b1, 1'b0, 1'b0); #1;
    chk("nolu_stall", 32'(stall_out), 32'd0);
    tick();
    chk("nolu_valid", 32'(dec_valid), 32'd1);
    chk("nolu_pc", 32'(dec_pc), 32'd9);

    drive(I_ADDI, 6'd10, 1'b1, 1'b1, 1'b1); tick();
    chk("flush_wins", 32'(dec_valid), 32'd0);

    drive(I_ADDI, 6'd11, 1'b1, 1'b0, 1'b0); tick();
    for (int k = 0; k < 3; k++) begin
      drive(I_LUI, 6'd12, 1'b1, 1'b1, 1'b0); tick();
      chk("hold_pc", 32'(dec_pc), 32'd11);
      chk("hold_imm", dec_imm, 32'hFFFFFFFB);
    end

    drive(32'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    wb(5'd7, 32'h12345678);
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    drive(I_ADD87, 6'd13, 1'b1, 1'b0, 1'b0); tick();
`ifdef DECODE_WB_BYPASS_EN
    chk("wb_same_cycle", dec_rs1_data, 32'hDEADBEEF);
`else
    chk("wb_same_cycle", dec_rs1_data, 32'h12345678);
`endif
    wb_en = 1'b0; tick();
    chk("wb_next_cycle", dec_rs1_data, 32'hDEADBEEF);

    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFFFFFF;
    drive(I_ADD80, 6'd14, 1'b1, 1'b0, 1'b0); tick();
    chk("x0_same_cycle", dec_rs1_data, 32'd0);
    wb_en = 1'b0; tick();
    chk("x0_after", dec_rs1_data, 32'd0);

    drive(32'h00000000, 6'd15, 1'b1, 1'b0, 1'b0); tick();
    chk("illegal_set", 32'(dec_illegal), 32'd1);
    chk("illegal_valid", 32'(dec_valid), 32'd1);
    drive(32'h00000000, 6'd0, 1'b0, 1'b0, 1'b0); tick();
    chk("illegal_nofv", 32'(dec_illegal), 32'd0);

    // asynchronous reset mid-run
    drive(I_ADDI, 6'd16, 1'b1, 1'b0, 1'b0); tick();
    stall_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(dec_valid), 32'd0);
    chk("arst_pc", 32'(dec_pc), 32'd0);
    chk("arst_imm", dec_imm, 32'd0);
    chk("arst_stall_in", 32'(stall_out), 32'd1);
    stall_in = 1'b0;
    #1;
    chk("arst_stall_fall", 32'(stall_out), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    drive(I_ADD81, 6'd17, 1'b1, 1'b0, 1'b0); tick();
    chk("post_rst_valid", 32'(dec_valid), 32'd1);
    chk("post_rst_x1", dec_rs1_data, 32'd0);

    drive(32'd0, 6'd0, 1'b0, 1'b0, 1'b0); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
